// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM main controller: Moore state sequencer, ALU decoder
// and CondEx gating of every architectural write strobe.
module arm_multicycle_ctrl #(
    parameter bit UNDEF_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic [3:0] State,
    output logic       Halted
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMREAD = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        HALT    = 4'd10
    } state_e;

    state_e state_q, state_d;

    logic next_pc, branch, regw, memw, irw, alu_op;
    logic is_add, is_sub, is_and, is_orr, is_cmp;
    logic pcs;
    logic [1:0] flag_w_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNDEF_TRAP ? HALT : FETCH;
                endcase
            end
            MEMADR:  state_d = Funct[0] ? MEMREAD : MEMWR;
            MEMREAD: state_d = MEMWB;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Ungated per-state strobes and mux selects
    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        irw       = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        case (state_q)
            FETCH: begin
                irw       = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:  ALUSrcB = 2'b01;
            MEMREAD: AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            EXECR:   alu_op = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB:   regw = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign is_add = alu_op & (Funct[4:1] == 4'b0100);
    assign is_sub = alu_op & (Funct[4:1] == 4'b0010);
    assign is_and = alu_op & (Funct[4:1] == 4'b0000);
    assign is_orr = alu_op & (Funct[4:1] == 4'b1100);
    assign is_cmp = alu_op & (Funct[4:1] == 4'b1010);

    always_comb begin
        ALUControl = 2'b00;
        if (is_sub | is_cmp) ALUControl = 2'b01;
        else if (is_and)     ALUControl = 2'b10;
        else if (is_orr)     ALUControl = 2'b11;
    end

    // CMP updates all flags even without the S bit
    assign flag_w_raw = is_cmp ? 2'b11 :
        {alu_op & Funct[0], alu_op & Funct[0] & (is_add | is_sub)};

    assign pcs      = ((Rd == 4'd15) & regw) | branch;
    assign PCWrite  = reset & (next_pc | (pcs & CondEx));
    assign RegWrite = reset & regw & CondEx & ~is_cmp;
    assign MemWrite = reset & memw & CondEx;
    assign IRWrite  = reset & irw;
    assign FlagW    = {2{reset & CondEx}} & flag_w_raw;
    assign Halted   = reset & (state_q == HALT);
    assign State    = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: two instances (trap off/on) against an
// instruction-level model, plus literal state/strobe traces.
module tb_arm_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic       CondEx = 1'b0;

    logic       pcw_o[2];
    logic       adr_o[2];
    logic       mw_o[2];
    logic       irw_o[2];
    logic [1:0] rs_o[2];
    logic       sa_o[2];
    logic [1:0] sb_o[2];
    logic       rw_o[2];
    logic [1:0] alc_o[2];
    logic [1:0] fw_o[2];
    logic [3:0] st_o[2];
    logic       h_o[2];

    always #5 clk = ~clk;

    arm_multicycle_ctrl #(.UNDEF_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .CondEx(CondEx), .PCWrite(pcw_o[0]), .AdrSrc(adr_o[0]),
        .MemWrite(mw_o[0]), .IRWrite(irw_o[0]), .ResultSrc(rs_o[0]),
        .ALUSrcA(sa_o[0]), .ALUSrcB(sb_o[0]), .RegWrite(rw_o[0]),
        .ALUControl(alc_o[0]), .FlagW(fw_o[0]), .State(st_o[0]),
        .Halted(h_o[0])
    );

    arm_multicycle_ctrl #(.UNDEF_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .CondEx(CondEx), .PCWrite(pcw_o[1]), .AdrSrc(adr_o[1]),
        .MemWrite(mw_o[1]), .IRWrite(irw_o[1]), .ResultSrc(rs_o[1]),
        .ALUSrcA(sa_o[1]), .ALUSrcB(sb_o[1]), .RegWrite(rw_o[1]),
        .ALUControl(alc_o[1]), .FlagW(fw_o[1]), .State(st_o[1]),
        .Halted(h_o[1])
    );

    int tests = 0;
    int fails = 0;

    // Instruction-level model: st0 is the architectural step of the
    // non-trapping core; the trapping core matches it until it halts.
    int  st0 = 0;
    bit  halted1 = 1'b0;
    int  q0[$];
    logic [11:0] dir_q[$];
    int  force_cond = -1;
    bit  rand_rst = 1'b0;
    int  rst_hold = 0;

    logic [31:0] smp_st0, smp_str0, smp_fl0, smp_irw0, smp_st1, smp_h1;
    logic [31:0] smp_any0, smp_mw0;
    logic [31:0] first_irw, first_st;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h",
                     nm, id, $time, act, exp);
        end
    endtask

    task automatic check_dut(input int id, input int st);
        bit rn, ce, regw, memw, br, np, aluop;
        bit add, sub, an, orr, cmp, pcs;
        logic [1:0] alc, fw;
        logic [3:0] f;
        rn = reset;
        ce = CondEx;
        f = Funct[4:1];
        regw  = (st == 4) || (st == 8);
        memw  = (st == 5);
        br    = (st == 9);
        np    = (st == 0);
        aluop = (st == 6) || (st == 7);
        add = aluop && (f == 4'b0100);
        sub = aluop && (f == 4'b0010);
        an  = aluop && (f == 4'b0000);
        orr = aluop && (f == 4'b1100);
        cmp = aluop && (f == 4'b1010);
        alc = (sub || cmp) ? 2'd1 : an ? 2'd2 : orr ? 2'd3 : 2'd0;
        if (cmp) fw = 2'b11;
        else     fw = {Funct[0], Funct[0] && (add || sub)};
        if (!aluop || !(rn && ce)) fw = 2'b00;
        pcs = ((Rd == 4'd15) && regw) || br;
        chk("State", id, 32'(st_o[id]), 32'(st));
        chk("Halted", id, 32'(h_o[id]), 32'(rn && st == 10));
        chk("PCWrite", id, 32'(pcw_o[id]), 32'(rn && (np || (pcs && ce))));
        chk("RegWrite", id, 32'(rw_o[id]), 32'(rn && regw && ce && !cmp));
        chk("MemWrite", id, 32'(mw_o[id]), 32'(rn && memw && ce));
        chk("IRWrite", id, 32'(irw_o[id]), 32'(rn && np));
        chk("FlagW", id, 32'(fw_o[id]), 32'(fw));
        chk("ALUControl", id, 32'(alc_o[id]), 32'(alc));
        case (st)
            0, 1: begin
                if (st == 0) chk("AdrSrc", id, 32'(adr_o[id]), 32'd0);
                chk("ALUSrcA", id, 32'(sa_o[id]), 32'd1);
                chk("ALUSrcB", id, 32'(sb_o[id]), 32'd2);
                chk("ResultSrc", id, 32'(rs_o[id]), 32'd2);
            end
            2: begin
                chk("ALUSrcA", id, 32'(sa_o[id]), 32'd0);
                chk("ALUSrcB", id, 32'(sb_o[id]), 32'd1);
            end
            3, 5: begin
                chk("AdrSrc", id, 32'(adr_o[id]), 32'd1);
                chk("ResultSrc", id, 32'(rs_o[id]), 32'd0);
            end
            4: chk("ResultSrc", id, 32'(rs_o[id]), 32'd1);
            6, 7: begin
                chk("ALUSrcA", id, 32'(sa_o[id]), 32'd0);
                chk("ALUSrcB", id, 32'(sb_o[id]), 32'(st == 7));
            end
            8: chk("ResultSrc", id, 32'(rs_o[id]), 32'd0);
            9: begin
                chk("ALUSrcA", id, 32'(sa_o[id]), 32'd0);
                chk("ALUSrcB", id, 32'(sb_o[id]), 32'd1);
                chk("ResultSrc", id, 32'(rs_o[id]), 32'd2);
            end
            default: ;
        endcase
    endtask

    function automatic logic [11:0] rand_ins();
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] rd;
        logic [3:0] codes[5];
        int r;
        codes = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        r = int'($urandom_range(0, 15));
        op = (r < 5) ? 2'd0 : (r < 9) ? 2'd1 : (r < 13) ? 2'd2 : 2'd3;
        fn = 6'($urandom);
        if (op == 2'd0 && $urandom_range(0, 3) != 0)
            fn[4:1] = codes[$urandom_range(0, 4)];
        rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
        return {op, fn, rd};
    endfunction

    // Steps left after DECODE for each instruction class
    task automatic load_path();
        q0.delete();
        case (Op)
            2'd0: begin
                q0.push_back(Funct[5] ? 7 : 6);
                q0.push_back(8);
            end
            2'd1: begin
                q0.push_back(2);
                if (Funct[0]) begin
                    q0.push_back(3);
                    q0.push_back(4);
                end else begin
                    q0.push_back(5);
                end
            end
            2'd2: q0.push_back(9);
            default: ;
        endcase
    endtask

    task automatic step();
        logic [11:0] ins;
        @(negedge clk);
        check_dut(0, st0);
        check_dut(1, halted1 ? 10 : st0);
        smp_st0  = 32'(st_o[0]);
        smp_str0 = 32'({pcw_o[0], rw_o[0], mw_o[0]});
        smp_fl0  = 32'({fw_o[0], alc_o[0]});
        smp_irw0 = 32'(irw_o[0]);
        smp_st1  = 32'(st_o[1]);
        smp_h1   = 32'(h_o[1]);
        smp_mw0  = 32'(mw_o[0]);
        smp_any0 = 32'(pcw_o[0] | rw_o[0] | mw_o[0] | irw_o[0] |
                       (|fw_o[0]) | h_o[0]);
        @(posedge clk);
        if (reset) begin
            if (st0 == 0) begin
                st0 = 1;
            end else begin
                if (st0 == 1) begin
                    load_path();
                    if (Op == 2'd3) halted1 = 1'b1;
                end
                st0 = (q0.size() > 0) ? q0.pop_front() : 0;
            end
        end
        #1;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) reset = 1'b1;
        end else if (rand_rst && $urandom_range(0, 59) == 0) begin
            reset = 1'b0;
            rst_hold = int'($urandom_range(1, 3));
            st0 = 0;
            halted1 = 1'b0;
            q0.delete();
        end
        if (reset && st0 == 1) begin
            ins = (dir_q.size() > 0) ? dir_q.pop_front() : rand_ins();
            Op = ins[11:10];
            Funct = ins[9:4];
            Rd = ins[3:0];
        end
        CondEx = (force_cond >= 0) ? force_cond[0] : 1'($urandom);
    endtask

    task automatic run_directed(input string nm, input logic [1:0] op,
                                input logic [5:0] fn, input logic [3:0] rd,
                                input int cond, input logic [31:0] es,
                                input logic [31:0] estr,
                                input logic [31:0] efl);
        logic [31:0] vs, vt, vf;
        int n;
        dir_q.push_back({op, fn, rd});
        force_cond = cond;
        CondEx = cond[0];
        vs = 0;
        vt = 0;
        vf = 0;
        n = 0;
        do begin
            step();
            if (n == 0) begin
                first_irw = smp_irw0;
                first_st = smp_st0;
            end
            vs = (vs << 4) | smp_st0;
            vt = (vt << 4) | smp_str0;
            vf = (vf << 4) | smp_fl0;
            n++;
        end while (st0 != 0 && n < 16);
        force_cond = -1;
        chk({nm, "_timeout"}, 0, 32'(n < 16), 32'd1);
        chk({nm, "_states"}, 0, vs, es);
        chk({nm, "_strobes"}, 0, vt, estr);
        chk({nm, "_alu"}, 0, vf, efl);
    endtask

    initial begin
        int cnt;
        logic [31:0] any;
        any = 0;
        rst_hold = 3;
        repeat (3) begin
            step();
            any = any | smp_any0;
        end
        chk("reset_strobes", 0, any, 32'd0);

        // Traces: state nibbles, {PCWrite,RegWrite,MemWrite}, {FlagW,ALUControl}
        run_directed("add_imm", 2'b00, 6'b101000, 4'd2, 1,
                     32'h0178, 32'h4002, 32'h0000);
        chk("rel_state", 0, first_st, 32'd0);
        chk("rel_irw", 0, first_irw, 32'd1);
        run_directed("ldr", 2'b01, 6'b011001, 4'd1, 1,
                     32'h01234, 32'h40002, 32'h00000);
        run_directed("str", 2'b01, 6'b011000, 4'd1, 1,
                     32'h0125, 32'h4001, 32'h0000);
        run_directed("subs", 2'b00, 6'b000101, 4'd3, 1,
                     32'h0168, 32'h4002, 32'h00D0);
        run_directed("cmp_nc", 2'b00, 6'b010101, 4'd0, 0,
                     32'h0168, 32'h4000, 32'h0010);
        run_directed("b_c", 2'b10, 6'b000000, 4'd0, 1,
                     32'h019, 32'h404, 32'h000);
        run_directed("b_nc", 2'b10, 6'b000000, 4'd0, 0,
                     32'h019, 32'h400, 32'h000);
        run_directed("orr_pc", 2'b00, 6'b011000, 4'd15, 1,
                     32'h0168, 32'h4006, 32'h0030);
        run_directed("undef", 2'b11, 6'b000000, 4'd0, 1,
                     32'h01, 32'h40, 32'h00);

        cnt = 0;
        repeat (20) begin
            step();
            if (smp_st1 == 32'd10 && smp_h1 == 32'd1) cnt++;
        end
        chk("trap_hold", 1, 32'(cnt), 32'd20);

        // Reset in MEMREAD of an LDR aborts before any write
        while (st0 != 0) step();
        dir_q.push_back({2'b01, 6'b011001, 4'd4});
        force_cond = 1;
        cnt = 0;
        while (st0 != 3 && cnt < 10) begin
            step();
            cnt++;
        end
        chk("mid_ldr_reach", 0, 32'(st0), 32'd3);
        reset = 1'b0;
        st0 = 0;
        halted1 = 1'b0;
        q0.delete();
        #1;
        chk("mid_ldr_state", 0, 32'(st_o[0]), 32'd0);
        chk("mid_ldr_state", 1, 32'(st_o[1]), 32'd0);
        rst_hold = 2;
        any = 0;
        repeat (3) begin
            step();
            any = any | smp_mw0;
        end
        chk("mid_ldr_nomw", 0, any, 32'd0);
        force_cond = -1;

        rand_rst = 1'b1;
        repeat (3000) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
